// File: rtl/alu_share_arbiter_if.sv
// Bundle of the requester handshakes, the shared-ALU drive/return and the response channels
// of alu_share_arbiter; slave is the arbiter side, master the surrounding environment.
interface alu_share_arbiter_if #(
    parameter int XLEN = 32
);
    logic            req0_valid;
    logic            req0_ready;
    logic [3:0]      req0_op;
    logic [XLEN-1:0] req0_a;
    logic [XLEN-1:0] req0_b;

    logic            req1_valid;
    logic            req1_ready;
    logic [3:0]      req1_op;
    logic [XLEN-1:0] req1_a;
    logic [XLEN-1:0] req1_b;

    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;

    logic            rsp0_valid;
    logic            rsp0_ready;
    logic [XLEN-1:0] rsp0_data;

    logic            rsp1_valid;
    logic            rsp1_ready;
    logic [XLEN-1:0] rsp1_data;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_result, rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output alu_op, alu_a, alu_b,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_result, rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  alu_op, alu_a, alu_b,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational integer ALU between two requesters: round-robin grant in IDLE,
// one EXEC cycle on registered operands, result parked on the owner's response channel.
module alu_share_arbiter #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic            lastGrant_q, lastGrant_d;
    logic            owner_q, owner_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            rsp0Valid_q, rsp0Valid_d;
    logic            rsp1Valid_q, rsp1Valid_d;
    logic [XLEN-1:0] rsp0Data_q, rsp0Data_d;
    logic [XLEN-1:0] rsp1Data_q, rsp1Data_d;

    logic elig0, elig1, grant, accept;
    logic req0Ready, req1Ready;

    // A port with a result still waiting to be consumed cannot issue another operation.
    assign elig0 = bus.req0_valid & ~rsp0Valid_q;
    assign elig1 = bus.req1_valid & ~rsp1Valid_q;

    always_comb begin
        grant = elig1;
        if (elig0 && elig1) begin
            grant = ~lastGrant_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0Ready = 1'b0;
        req1Ready = 1'b0;
        if (state_q == IDLE) begin
            req0Ready = elig0 & ~grant;
            req1Ready = elig1 & grant;
        end
    end

    assign accept = req0Ready | req1Ready;

    always_comb begin
        lastGrant_d = lastGrant_q;
        owner_d     = owner_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp0Valid_d = rsp0Valid_q;
        rsp1Valid_d = rsp1Valid_q;
        rsp0Data_d  = rsp0Data_q;
        rsp1Data_d  = rsp1Data_q;

        if (accept) begin
            lastGrant_d = grant;
            owner_d     = grant;
            op_d        = grant ? bus.req1_op : bus.req0_op;
            a_d         = grant ? bus.req1_a  : bus.req0_a;
            b_d         = grant ? bus.req1_b  : bus.req0_b;
        end

        if (rsp0Valid_q && bus.rsp0_ready) rsp0Valid_d = 1'b0;
        if (rsp1Valid_q && bus.rsp1_ready) rsp1Valid_d = 1'b0;

        // The owner's response slot is always empty here, so setting never races a consume.
        if (state_q == EXEC) begin
            if (owner_q) begin
                rsp1Valid_d = 1'b1;
                rsp1Data_d  = bus.alu_result;
            end else begin
                rsp0Valid_d = 1'b1;
                rsp0Data_d  = bus.alu_result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGrant_q <= 1'b1;
            owner_q     <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp0Valid_q <= 1'b0;
            rsp1Valid_q <= 1'b0;
            rsp0Data_q  <= '0;
            rsp1Data_q  <= '0;
        end else begin
            lastGrant_q <= lastGrant_d;
            owner_q     <= owner_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp0Valid_q <= rsp0Valid_d;
            rsp1Valid_q <= rsp1Valid_d;
            rsp0Data_q  <= rsp0Data_d;
            rsp1Data_q  <= rsp1Data_d;
        end
    end

    assign bus.req0_ready = req0Ready;
    assign bus.req1_ready = req1Ready;
    assign bus.alu_op     = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.rsp0_valid = rsp0Valid_q;
    assign bus.rsp0_data  = rsp0Data_q;
    assign bus.rsp1_valid = rsp1Valid_q;
    assign bus.rsp1_data  = rsp1Data_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized bench for alu_share_arbiter against a transaction-level model of
// the two-port sharing rules; the bench also plays the role of the shared ALU.
module tb_alu_share_arbiter;
    logic clk;
    logic rst_n;

    alu_share_arbiter_if #(.XLEN(32)) bus ();

    alu_share_arbiter #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors;
    int miscompares;
    int acc0, acc1;

    bit          mExec;
    bit          mOwner;
    bit          mLast;
    logic [3:0]  mOp;
    logic [31:0] mA, mB;
    bit          mRspV [2];
    logic [31:0] mRspD [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU; undefined codes return an arbitrary but deterministic mix of the operands.
    function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return $signed(a) >>> b[4:0];
            4'd8:    return {31'd0, $signed(a) < $signed(b)};
            4'd9:    return {31'd0, a < b};
            default: return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign bus.alu_result = refAlu(bus.alu_op, bus.alu_a, bus.alu_b);

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mExec    = 1'b0;
        mOwner   = 1'b0;
        mLast    = 1'b1;
        mOp      = '0;
        mA       = '0;
        mB       = '0;
        mRspV[0] = 1'b0;
        mRspV[1] = 1'b0;
        mRspD[0] = '0;
        mRspD[1] = '0;
    endtask

    task automatic checkAll(input bit x0, input bit x1);
        checkOutput("req0_ready", bus.req0_ready, x0);
        checkOutput("req1_ready", bus.req1_ready, x1);
        checkOutput("rsp0_valid", bus.rsp0_valid, mRspV[0]);
        checkOutput("rsp1_valid", bus.rsp1_valid, mRspV[1]);
        checkOutput("rsp0_data",  bus.rsp0_data,  mRspD[0]);
        checkOutput("rsp1_data",  bus.rsp1_data,  mRspD[1]);
        checkOutput("alu_op",     bus.alu_op,     mOp);
        checkOutput("alu_a",      bus.alu_a,      mA);
        checkOutput("alu_b",      bus.alu_b,      mB);
    endtask

    // One clock cycle: drive at the falling edge, check mid-cycle, advance the model at the rising edge.
    task automatic applyStimulus(input bit v0, input logic [3:0] op0, input logic [31:0] a0,
                                 input logic [31:0] b0, input bit v1, input logic [3:0] op1,
                                 input logic [31:0] a1, input logic [31:0] b1,
                                 input bit rr0, input bit rr1);
        bit e0, e1, win, x0, x1;
        @(negedge clk);
        bus.req0_valid = v0;
        bus.req0_op    = op0;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req1_valid = v1;
        bus.req1_op    = op1;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
        bus.rsp0_ready = rr0;
        bus.rsp1_ready = rr1;
        #1;
        e0  = v0 && !mRspV[0];
        e1  = v1 && !mRspV[1];
        win = (e0 && e1) ? !mLast : e1;
        x0  = !mExec && e0 && !win;
        x1  = !mExec && e1 && win;
        checkAll(x0, x1);
        if (bus.req0_ready && v0) acc0++;
        if (bus.req1_ready && v1) acc1++;
        @(posedge clk);
        if (mRspV[0] && rr0) mRspV[0] = 1'b0;
        if (mRspV[1] && rr1) mRspV[1] = 1'b0;
        if (mExec) begin
            mRspV[mOwner] = 1'b1;
            mRspD[mOwner] = refAlu(mOp, mA, mB);
            mExec         = 1'b0;
        end else if (x0 || x1) begin
            mExec  = 1'b1;
            mOwner = x1;
            mLast  = x1;
            mOp    = x1 ? op1 : op0;
            mA     = x1 ? a1 : a0;
            mB     = x1 ? b1 : b0;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n          = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        modelReset();
        checkAll(1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idleSteps(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    initial begin
        logic [31:0] pa, pb;
        vectors        = 0;
        miscompares    = 0;
        acc0           = 0;
        acc1           = 0;
        rst_n          = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_op    = '0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_op    = '0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        modelReset();
        doReset();

        applyStimulus(1, 4'd0, 5, 3, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        checkOutput("single_rsp0_valid", bus.rsp0_valid, 1);
        checkOutput("single_rsp0_data", bus.rsp0_data, 8);

        applyStimulus(1, 4'd0, 7, 7, 1, 4'd8, 32'hFFFF_FFFF, 1, 0, 1);
        applyStimulus(1, 4'd0, 7, 7, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("bp_rsp1_data", bus.rsp1_data, 1);
        checkOutput("bp_rsp0_held", bus.rsp0_data, 8);
        applyStimulus(1, 4'd0, 7, 7, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 4'd0, 7, 7, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        checkOutput("bp_rsp0_new", bus.rsp0_data, 14);
        idleSteps(2);

        acc0 = 0;
        acc1 = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 4'($urandom_range(0, 9)), $urandom, $urandom,
                          1, 4'($urandom_range(0, 9)), $urandom, $urandom, 1, 1);
        end
        checkOutput("fair_grants0", acc0, 5);
        checkOutput("fair_grants1", acc1, 5);
        idleSteps(2);

        pa = 32'h1234_5678;
        pb = 32'h0F0F_A5A5;
        applyStimulus(1, 4'hF, pa, pb, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        checkOutput("pass_rsp0_data", bus.rsp0_data, refAlu(4'hF, pa, pb));
        idleSteps(2);

        applyStimulus(0, 0, 0, 0, 1, 4'd7, 32'h8000_0000, 4, 1, 1);
        doReset();
        idleSteps(2);
        #1;
        checkOutput("rst_rsp1_valid", bus.rsp1_valid, 0);

        applyStimulus(1, 4'd1, 10, 4, 1, 4'd4, 32'hF0, 32'h0F, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 4'd4, 32'hF0, 32'h0F, 1, 1);
        #1;
        checkOutput("tie_rsp0_data", bus.rsp0_data, 6);
        checkOutput("tie_rsp1_pending", bus.rsp1_valid, 0);
        applyStimulus(0, 0, 0, 0, 1, 4'd4, 32'hF0, 32'h0F, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1;
        checkOutput("tie_rsp1_data", bus.rsp1_data, 32'hFF);
        idleSteps(2);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)),
                              $urandom, $urandom,
                              $urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)),
                              $urandom, $urandom,
                              $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
